// File: rtl/battle_turn_ctrl.sv
// Turn sequencer for a two-party battle: issues player/enemy attack strobes,
// waits for HP-block acknowledges with timeout, and tracks rounds and outcome.
module battle_turn_ctrl #(
  parameter int ENEMY_DELAY = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       move_valid,
  input  logic [1:0] move,
  input  logic [7:0] HP_p,
  input  logic [7:0] HP_e,
  input  logic       HP_p_en,
  input  logic       HP_e_en,
  output logic [1:0] attack_p,
  output logic       att_p_en,
  output logic [1:0] attack_e,
  output logic       att_e_en,
  output logic [2:0] state,
  output logic [7:0] turn_cnt,
  output logic       win,
  output logic       lose,
  output logic       ack_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P_TURN = 3'd1,
    P_ACK  = 3'd2,
    E_WAIT = 3'd3,
    E_ACK  = 3'd4,
    WIN    = 3'd5,
    LOSE   = 3'd6
  } state_t;

  localparam logic [7:0] DLY_LAST = 8'(ENEMY_DELAY - 1);
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     cur;
  logic [7:0] lfsr;
  logic [7:0] dly_cnt;
  logic [7:0] tmo_cnt;
  logic       restart_armed;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Fibonacci form, taps 8,6,5,4: feedback enters at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] r);
    return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
  endfunction

  // Code 0 would be a no-damage attack, so the enemy always hits for at least 1.
  function automatic logic [1:0] enemy_code(input logic [7:0] r);
    return (r[1:0] == 2'b00) ? 2'b01 : r[1:0];
  endfunction

  assign state = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur           <= IDLE;
      attack_p      <= 2'b00;
      attack_e      <= 2'b00;
      att_p_en      <= 1'b0;
      att_e_en      <= 1'b0;
      turn_cnt      <= 8'd0;
      win           <= 1'b0;
      lose          <= 1'b0;
      ack_err       <= 1'b0;
      dly_cnt       <= 8'd0;
      tmo_cnt       <= 8'd0;
      lfsr          <= 8'h5A;
      restart_armed <= 1'b0;
    end else begin
      lfsr     <= lfsr_next(lfsr);
      att_p_en <= 1'b0;
      att_e_en <= 1'b0;
      case (cur)
        IDLE: begin
          if (start) begin
            cur      <= P_TURN;
            win      <= 1'b0;
            lose     <= 1'b0;
            ack_err  <= 1'b0;
            turn_cnt <= 8'd0;
          end
        end
        P_TURN: begin
          if (move_valid) begin
            cur      <= P_ACK;
            attack_p <= move;
            att_p_en <= 1'b1;
            tmo_cnt  <= 8'd0;
          end
        end
        P_ACK: begin
          if (HP_e_en || tmo_cnt == TMO_LAST) begin
            if (!HP_e_en) ack_err <= 1'b1;
            if (HP_e == 8'd0) begin
              cur           <= WIN;
              win           <= 1'b1;
              restart_armed <= 1'b0;
            end else begin
              cur     <= E_WAIT;
              dly_cnt <= 8'd0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        E_WAIT: begin
          if (dly_cnt == DLY_LAST) begin
            cur      <= E_ACK;
            attack_e <= enemy_code(lfsr);
            att_e_en <= 1'b1;
            tmo_cnt  <= 8'd0;
          end else begin
            dly_cnt <= dly_cnt + 8'd1;
          end
        end
        E_ACK: begin
          if (HP_p_en || tmo_cnt == TMO_LAST) begin
            if (!HP_p_en) ack_err <= 1'b1;
            if (HP_p == 8'd0) begin
              cur           <= LOSE;
              lose          <= 1'b1;
              restart_armed <= 1'b0;
            end else begin
              cur      <= P_TURN;
              turn_cnt <= sat_inc(turn_cnt);
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        // A restart needs start seen low inside WIN/LOSE before it is seen high again.
        WIN, LOSE: begin
          if (!start) restart_armed <= 1'b1;
          else if (restart_armed) cur <= IDLE;
        end
        default: cur <= IDLE;
      endcase
    end
  end

endmodule
